// File: rtl/baud_tick_scheduler.sv
// Sequences an external free-running baud divider so that start, stop and divisor
// changes land on wrap boundaries. Define BAUD_TICK_CNT_EN to add tick_bit_count.
//
// state    | meaning
// IDLE     | divider disabled, its counter parked at 0
// RUN      | divider enabled, ticks issued
// STOPPING | still ticking; returns to IDLE on the next wrap
module baud_tick_scheduler #(
    parameter int unsigned     BITS      = 16,
    parameter int unsigned     OS_RATE   = 16,
    parameter logic [BITS-1:0] RESET_DIV = 16'd650
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stop,
    input  logic            bit_sync,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [BITS-1:0] cfg_divisor,
    output logic            brg_enable,
    output logic [BITS-1:0] brg_final_value,
    input  logic            brg_done,
    output logic            tick_os,
    output logic            tick_bit,
    output logic            running,
    output logic            cfg_pending
`ifdef BAUD_TICK_CNT_EN
    ,
    output logic [15:0]     tick_bit_count
`endif
);

    localparam int unsigned      OSW     = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
    localparam logic [OSW-1:0]   OS_LAST = OSW'(OS_RATE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            brg_enable_q, brg_enable_d;
    logic [BITS-1:0] final_q, final_d;
    logic [BITS-1:0] shadow_q, shadow_d;
    logic            cfg_pending_q, cfg_pending_d;
    logic            tick_os_q, tick_os_d;
    logic            tick_bit_q, tick_bit_d;
    logic [OSW-1:0]  os_cnt_q, os_cnt_d;
    logic            wrap;
    logic            xfer;
    logic            to_idle;

    always_comb begin
        wrap  = brg_enable_q & brg_done;
        xfer  = cfg_valid & ~cfg_pending_q;

        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = RUN;
            RUN:      if (stop) state_d = STOPPING;
            STOPPING: begin
                if (start && !stop) state_d = RUN;
                else if (wrap)      state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        to_idle      = (state_q != IDLE) && (state_d == IDLE);
        brg_enable_d = (state_d != IDLE);

        final_d       = final_q;
        shadow_d      = shadow_q;
        cfg_pending_d = cfg_pending_q;
        if (state_q == IDLE) begin
            if (xfer) final_d = cfg_divisor;
        end else begin
            if (wrap && cfg_pending_q) begin
                final_d       = shadow_q;
                cfg_pending_d = 1'b0;
            end
            // An offer on the final wrap goes straight in: the divider is parked at 0.
            if (xfer) begin
                if (to_idle) begin
                    final_d = cfg_divisor;
                end else begin
                    shadow_d      = cfg_divisor;
                    cfg_pending_d = 1'b1;
                end
            end
        end

        tick_os_d  = wrap;
        tick_bit_d = 1'b0;
        os_cnt_d   = os_cnt_q;
        if (bit_sync) begin
            os_cnt_d = '0;
        end else if (wrap) begin
            if (os_cnt_q == OS_LAST) begin
                os_cnt_d   = '0;
                tick_bit_d = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + 1'b1;
            end
        end
        if (to_idle) os_cnt_d = '0;
    end

`ifdef BAUD_TICK_CNT_EN
    logic [15:0] tick_bit_count_q, tick_bit_count_d;

    always_comb begin
        tick_bit_count_d = tick_bit_count_q;
        if (tick_bit_q) tick_bit_count_d = tick_bit_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tick_bit_count_q <= '0;
        else          tick_bit_count_q <= tick_bit_count_d;
    end

    assign tick_bit_count = tick_bit_count_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            brg_enable_q  <= 1'b0;
            final_q       <= RESET_DIV;
            shadow_q      <= '0;
            cfg_pending_q <= 1'b0;
            tick_os_q     <= 1'b0;
            tick_bit_q    <= 1'b0;
            os_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            brg_enable_q  <= brg_enable_d;
            final_q       <= final_d;
            shadow_q      <= shadow_d;
            cfg_pending_q <= cfg_pending_d;
            tick_os_q     <= tick_os_d;
            tick_bit_q    <= tick_bit_d;
            os_cnt_q      <= os_cnt_d;
        end
    end

    assign cfg_ready       = ~cfg_pending_q;
    assign running         = (state_q != IDLE);
    assign brg_enable      = brg_enable_q;
    assign brg_final_value = final_q;
    assign tick_os         = tick_os_q;
    assign tick_bit        = tick_bit_q;
    assign cfg_pending     = cfg_pending_q;

endmodule

// File: tb/tb_baud_tick_scheduler.sv
// Bench for baud_tick_scheduler: a behavioural divider stub drives brg_done, and tick
// timing is predicted arithmetically from the divisor and the edge index since start.
module tb_baud_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        bit_sync = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_divisor = 16'd0;
    logic        cfg_ready, brg_enable, brg_done, tick_os, tick_bit, running, cfg_pending;
    logic [15:0] brg_final_value;
    logic [15:0] gen_cnt;
    int          checks = 0;
    int          failures = 0;
    int          n;
    int          d;
`ifdef BAUD_TICK_CNT_EN
    logic [15:0] tick_bit_count;
    int          bits_seen = 0;
`endif

    baud_tick_scheduler dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .stop            (stop),
        .bit_sync        (bit_sync),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_divisor     (cfg_divisor),
        .brg_enable      (brg_enable),
        .brg_final_value (brg_final_value),
        .brg_done        (brg_done),
        .tick_os         (tick_os),
        .tick_bit        (tick_bit),
        .running         (running),
        .cfg_pending     (cfg_pending)
`ifdef BAUD_TICK_CNT_EN
        ,
        .tick_bit_count  (tick_bit_count)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the external free-running divider.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        gen_cnt <= 16'd0;
        else if (brg_enable) gen_cnt <= (gen_cnt == brg_final_value) ? 16'd0 : gen_cnt + 16'd1;
    end
    assign brg_done = brg_enable && (gen_cnt == brg_final_value);

`ifdef BAUD_TICK_CNT_EN
    always @(posedge clk) if (reset_n && tick_bit) bits_seen <= bits_seen + 1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Configure divisor dv in IDLE, start, then predict every edge until well after stop.
    task automatic trial(input int dv, input int stop_edge, input int sync_edge, input bit rnd_sync);
        int s, since, idle_at, total;
        bit stopping, bs, st, wrap_now, exp_bit;
        cfg_divisor = 16'(dv);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("idle_cfg_value", 32'(brg_final_value), 32'(dv));
        check("idle_cfg_no_pending", 32'(cfg_pending), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_enable", 32'(brg_enable), 32'd1);
        check("start_running", 32'(running), 32'd1);
        s = 0; since = 0; idle_at = -1; stopping = 1'b0;
        total = stop_edge + 2 * (dv + 1) + 4;
        while (s < total) begin
            s++;
            bs = (s == sync_edge) || (rnd_sync && ($urandom_range(0, 24) == 0));
            st = (s == stop_edge);
            bit_sync = bs;
            stop = st;
            tick();
            bit_sync = 1'b0;
            stop = 1'b0;
            wrap_now = (idle_at < 0) && (s % (dv + 1) == 0);
            if (bs)            since = 0;
            else if (wrap_now) since++;
            exp_bit = wrap_now && !bs && (since > 0) && (since % 16 == 0);
            if (wrap_now && stopping) idle_at = s;
            if (st) stopping = 1'b1;
            check("tick_os", 32'(tick_os), 32'(wrap_now));
            check("tick_bit", 32'(tick_bit), 32'(exp_bit));
            check("running", 32'(running), 32'(idle_at < 0));
            if (idle_at == s) begin
                check("stop_enable_low", 32'(brg_enable), 32'd0);
                check("stop_gen_cnt_zero", 32'(gen_cnt), 32'd0);
            end
        end
    endtask

    // Edges until the next tick_os, capped at 100.
    task automatic edges_to_tick(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!tick_os && cnt < 100);
    endtask

    initial begin
        tick();
        tick();
        check("rst_enable", 32'(brg_enable), 32'd0);
        check("rst_final", 32'(brg_final_value), 32'd650);
        check("rst_tick_os", 32'(tick_os), 32'd0);
        check("rst_tick_bit", 32'(tick_bit), 32'd0);
        check("rst_pending", 32'(cfg_pending), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        reset_n = 1'b1;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_ignored", 32'(running), 32'd0);

        trial(9, 400, -1, 1'b0);
        trial(2, 150, 48, 1'b0);

        // Divisor 9 running; offer 4 with the divider at count 6.
        cfg_divisor = 16'd9; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (gen_cnt != 16'd6 && n < 50) begin tick(); n++; end
        check("reach_cnt6", 32'(gen_cnt), 32'd6);
        cfg_divisor = 16'd4; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        check("recfg_pending", 32'(cfg_pending), 32'd1);
        check("recfg_ready", 32'(cfg_ready), 32'd0);
        check("recfg_old_value", 32'(brg_final_value), 32'd9);
        edges_to_tick(n);
        check("recfg_old_period_tail", 32'(n), 32'd3);
        check("recfg_applied", 32'(brg_final_value), 32'd4);
        check("recfg_pending_clear", 32'(cfg_pending), 32'd0);
        edges_to_tick(n);
        check("recfg_new_period1", 32'(n), 32'd5);
        edges_to_tick(n);
        check("recfg_new_period2", 32'(n), 32'd5);

        // start and stop together in RUN must stop at the next wrap.
        n = 0;
        while (gen_cnt != 16'd1 && n < 50) begin tick(); n++; end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        edges_to_tick(n);
        check("startstop_tail", 32'(n), 32'd3);
        check("startstop_running", 32'(running), 32'd0);
        check("startstop_enable", 32'(brg_enable), 32'd0);

        // stop then start in STOPPING keeps ticking with no gap.
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (gen_cnt != 16'd2 && n < 50) begin tick(); n++; end
        stop = 1'b1; tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tick_os) n++;
        end
        check("cancel_stop_ticks", 32'(n), 32'd3);
        check("cancel_stop_running", 32'(running), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        n = 0;
        while (running && n < 100) begin tick(); n++; end
        check("cancel_stop_then_stop", 32'(running), 32'd0);

        for (int t = 0; t < 4; t++) begin
            d = int'($urandom_range(0, 12));
            trial(d, int'($urandom_range(20 * (d + 1), 45 * (d + 1))), -1, 1'b1);
        end

`ifdef BAUD_TICK_CNT_EN
        tick();
        check("bit_count", 32'(tick_bit_count), 32'(bits_seen[15:0]));
`endif

        // Reset mid-run with a pending divisor.
        cfg_divisor = 16'd7; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        cfg_divisor = 16'd3; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        check("pre_rst_pending", 32'(cfg_pending), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_enable", 32'(brg_enable), 32'd0);
        check("mid_rst_final", 32'(brg_final_value), 32'd650);
        check("mid_rst_pending", 32'(cfg_pending), 32'd0);
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        check("mid_rst_running", 32'(running), 32'd0);
        check("mid_rst_tick_os", 32'(tick_os), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_final", 32'(brg_final_value), 32'd650);
        check("post_rst_running", 32'(running), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
